// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: FSM encodings, prefetch entry layout, opcode and field helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam int FIFO_ENTRY_W = 64;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_STALL   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic flushable FIFO (power-of-2 DEPTH) for the prefetch buffer and the request tag queue.
// Latency: a push is visible at the head the cycle after it is written; no bypass.
// Backpressure: push accepted when not full, or when full with a simultaneous pop (pop first).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_vld,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop_vld,
    output logic [WIDTH-1:0]        head_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with credit-checked prefetch buffer and redirect discard; FETCH_PERF_CNT_EN adds perf counters.
// Latency: request the cycle after reset; an instruction reaches if_* one cycle after its response.
// Backpressure: requests issue only while in-flight + buffered < FIFO_DEPTH; if_ready=0 fills buffer then stalls.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_nxt;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] discard_nxt;
    logic [31:0]   tag_pc;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_stale;
    logic          buf_push;
    logic          buf_pop;
    logic          credit_ok;
    logic          credit_nxt;

    // The tag queue occupancy is the in-flight count: one entry per accepted request.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push_vld (req_fire),
        .push_dat (fetch_pc),
        .pop_vld  (rsp_fire),
        .head_dat (tag_pc),
        .count    (inflight)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_ENTRY_W)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (buf_push),
        .push_dat (buf_in),
        .pop_vld  (buf_pop),
        .head_dat (buf_head),
        .count    (occ)
    );

    assign buf_in.pc   = tag_pc;
    assign buf_in.inst = imem_rsp_data;

    assign credit_ok  = ({1'b0, inflight} + {1'b0, occ}) < (CW+1)'(FIFO_DEPTH);
    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_fire   = imem_rsp_valid && (inflight != '0);
    assign rsp_stale  = rsp_fire && (discard_cnt != '0);
    assign buf_push   = rsp_fire && !rsp_stale && !redirect_valid;
    assign buf_pop    = if_valid && if_ready && !redirect_valid;

    assign inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_fire);
    assign occ_nxt      = redirect_valid ? '0 : (occ + CW'(buf_push) - CW'(buf_pop));
    assign credit_nxt   = ({1'b0, inflight_nxt} + {1'b0, occ_nxt}) < (CW+1)'(FIFO_DEPTH);
    // After a redirect every outstanding request is stale, so the leftover discards plus
    // the requests issued since the previous redirect sum to the whole in-flight count.
    assign discard_nxt  = redirect_valid ? inflight_nxt : (discard_cnt - CW'(rsp_stale));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
            if (redirect_valid)
                fetch_pc <= align_pc(redirect_pc);
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (discard_nxt != '0)  state_nxt = ST_DISCARD;
                else if (!credit_nxt)   state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (discard_nxt != '0)  state_nxt = ST_DISCARD;
                else if (credit_nxt)    state_nxt = ST_FETCH;
            end
            ST_DISCARD: begin
                if (discard_nxt == '0)  state_nxt = credit_nxt ? ST_FETCH : ST_STALL;
            end
            default:                    state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        case (state)
            ST_FETCH, ST_DISCARD: imem_req_valid = rst && credit_ok;
            default:              imem_req_valid = 1'b0;
        endcase
    end

    assign imem_req_addr = fetch_pc;
    assign if_valid      = (occ != '0);
    assign if_inst       = if_valid ? buf_head.inst : 32'd0;
    assign if_pc         = if_valid ? buf_head.pc   : 32'd0;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (buf_pop)               perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (if_ready && !if_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
